// File: rtl/rx_iq_src_ctrl.sv
// Source scheduler for the receive I/Q FIFO: muxes RF, loopback and ramp sources and
// sequences every source change through gate, drain, flush and settle phases.
module rx_iq_src_ctrl #(
  parameter int IQ_DATA_WIDTH  = 16,
  parameter int FLUSH_CYCLES   = 8,
  parameter int DRAIN_TIMEOUT  = 200,
  parameter int PATTERN_PERIOD = 5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [1:0]                 src_sel_req,
  input  logic                       src_sel_apply,
  input  logic [4*IQ_DATA_WIDTH-1:0] rf_iq,
  input  logic                       rf_iq_valid_in,
  input  logic [4*IQ_DATA_WIDTH-1:0] lb_iq,
  input  logic                       lb_iq_valid_in,
  input  logic                       fifo_emptyn,
  input  logic                       drop_clr,
  output logic [4*IQ_DATA_WIDTH-1:0] bw20_iq,
  output logic                       bw20_iq_valid,
  output logic                       fifo_in_en,
  output logic                       fifo_out_en,
  output logic                       fifo_rstn,
  output logic [1:0]                 src_sel_active,
  output logic                       busy,
  output logic [15:0]                drop_count,
  output logic                       drain_timeout_flag
);

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [4:0] PAT_LAST   = 5'(PATTERN_PERIOD - 1);

  typedef enum logic [2:0] {S_RUN, S_GATE, S_DRAIN, S_FLUSH, S_SETTLE} state_t;

  state_t                     state_reg, state_next;
  logic [7:0]                 cnt_reg, cnt_next;
  logic [1:0]                 target_reg, target_next;
  logic [1:0]                 pend_reg, pend_next;
  logic                       pend_valid_reg, pend_valid_next;
  logic [1:0]                 active_reg, active_next;
  logic [1:0]                 prev_src_reg;
  logic [4:0]                 div_reg;
  logic [IQ_DATA_WIDTH-1:0]   ramp_reg;
  logic [4*IQ_DATA_WIDTH-1:0] bw20_iq_reg;
  logic                       bw20_iq_valid_reg;
  logic                       fifo_in_en_reg, fifo_out_en_reg, fifo_rstn_reg, busy_reg;
  logic [15:0]                drop_count_reg;
  logic                       drain_timeout_flag_reg;
  logic                       timeout_hit;

  logic [1:0]                 req_m;
  logic [IQ_DATA_WIDTH-1:0]   ramp_p1;
  logic [4*IQ_DATA_WIDTH-1:0] pat_iq, sel_iq;
  logic                       pat_fire, sel_valid, drop_strobe;

  // Reserved code 3 falls back to the RF front-end.
  assign req_m    = (src_sel_req == 2'd3) ? 2'd0 : src_sel_req;
  assign ramp_p1  = ramp_reg + 1'b1;
  assign pat_iq   = {~ramp_p1, ramp_p1, ~ramp_reg, ramp_reg};
  assign pat_fire = (state_reg == S_RUN) && (div_reg == PAT_LAST);

  always_comb begin
    sel_iq      = rf_iq;
    sel_valid   = rf_iq_valid_in;
    drop_strobe = 1'b0;
    case (active_reg)
      2'd1:    begin sel_iq = lb_iq;  sel_valid = lb_iq_valid_in; end
      2'd2:    begin sel_iq = pat_iq; sel_valid = pat_fire;       end
      default: begin sel_iq = rf_iq;  sel_valid = rf_iq_valid_in; end
    endcase
    // Drops are charged to the source that was live before the switch began.
    case (prev_src_reg)
      2'd0:    drop_strobe = rf_iq_valid_in;
      2'd1:    drop_strobe = lb_iq_valid_in;
      default: drop_strobe = 1'b0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    target_next     = target_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    active_next     = active_reg;
    timeout_hit     = 1'b0;
    if (src_sel_apply && state_reg != S_RUN) begin
      pend_valid_next = 1'b1;
      pend_next       = req_m;
    end
    case (state_reg)
      S_RUN: begin
        pend_valid_next = 1'b0;
        if (src_sel_apply) begin
          if (req_m != active_reg) begin
            target_next = req_m;
            state_next  = S_GATE;
          end
        end else if (pend_valid_reg && pend_reg != active_reg) begin
          target_next = pend_reg;
          state_next  = S_GATE;
        end
      end
      S_GATE: begin
        state_next = S_DRAIN;
        cnt_next   = 8'd0;
      end
      S_DRAIN: begin
        if (!fifo_emptyn) begin
          state_next = S_FLUSH;
          cnt_next   = 8'd0;
        end else if (cnt_reg == DRAIN_LAST) begin
          state_next  = S_FLUSH;
          cnt_next    = 8'd0;
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_FLUSH: begin
        if (cnt_reg == FLUSH_LAST) begin
          state_next  = S_SETTLE;
          cnt_next    = 8'd0;
          active_next = target_reg;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_reg == 8'd1) begin
          state_next = S_RUN;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = S_FLUSH;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg              <= S_FLUSH;
      cnt_reg                <= 8'd0;
      target_reg             <= 2'd0;
      pend_reg               <= 2'd0;
      pend_valid_reg         <= 1'b0;
      active_reg             <= 2'd0;
      prev_src_reg           <= 2'd0;
      div_reg                <= 5'd0;
      ramp_reg               <= '0;
      bw20_iq_reg            <= '0;
      bw20_iq_valid_reg      <= 1'b0;
      fifo_in_en_reg         <= 1'b0;
      fifo_out_en_reg        <= 1'b0;
      fifo_rstn_reg          <= 1'b0;
      busy_reg               <= 1'b1;
      drop_count_reg         <= 16'd0;
      drain_timeout_flag_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      target_reg     <= target_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      active_reg     <= active_next;
      if (state_reg == S_RUN) prev_src_reg <= active_reg;
      // Divider and ramp sit at zero outside RUN so every RUN entry restarts the ramp.
      if (state_reg != S_RUN) begin
        div_reg  <= 5'd0;
        ramp_reg <= '0;
      end else if (pat_fire) begin
        div_reg  <= 5'd0;
        ramp_reg <= ramp_p1;
      end else begin
        div_reg <= div_reg + 5'd1;
      end
      bw20_iq_valid_reg <= (state_reg == S_RUN) && sel_valid;
      if (state_reg == S_RUN && sel_valid) bw20_iq_reg <= sel_iq;
      fifo_in_en_reg  <= (state_next == S_RUN);
      fifo_out_en_reg <= (state_next == S_RUN) || (state_next == S_GATE) || (state_next == S_DRAIN);
      fifo_rstn_reg   <= (state_next != S_FLUSH);
      busy_reg        <= (state_next != S_RUN);
      if (drop_clr)
        drop_count_reg <= 16'd0;
      else if (state_reg != S_RUN && drop_strobe && drop_count_reg != 16'hFFFF)
        drop_count_reg <= drop_count_reg + 16'd1;
      if (drop_clr)
        drain_timeout_flag_reg <= 1'b0;
      else if (timeout_hit)
        drain_timeout_flag_reg <= 1'b1;
    end
  end

  assign bw20_iq            = bw20_iq_reg;
  assign bw20_iq_valid      = bw20_iq_valid_reg;
  assign fifo_in_en         = fifo_in_en_reg;
  assign fifo_out_en        = fifo_out_en_reg;
  assign fifo_rstn          = fifo_rstn_reg;
  assign src_sel_active     = active_reg;
  assign busy               = busy_reg;
  assign drop_count         = drop_count_reg;
  assign drain_timeout_flag = drain_timeout_flag_reg;

endmodule

// File: tb/tb_rx_iq_src_ctrl.sv
// Directed bench for rx_iq_src_ctrl: vector table for the mux, hand sequences for switching.
module tb_rx_iq_src_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic [1:0]     src_sel_req;
  logic           src_sel_apply;
  logic [4*W-1:0] rf_iq, lb_iq;
  logic           rf_iq_valid_in, lb_iq_valid_in, fifo_emptyn, drop_clr;
  logic [4*W-1:0] bw20_iq;
  logic           bw20_iq_valid, fifo_in_en, fifo_out_en, fifo_rstn, busy, drain_timeout_flag;
  logic [1:0]     src_sel_active;
  logic [15:0]    drop_count;

  rx_iq_src_ctrl #(
    .IQ_DATA_WIDTH(W), .FLUSH_CYCLES(8), .DRAIN_TIMEOUT(200), .PATTERN_PERIOD(5)
  ) dut (
    .clk(clk), .rstn(rstn), .src_sel_req(src_sel_req), .src_sel_apply(src_sel_apply),
    .rf_iq(rf_iq), .rf_iq_valid_in(rf_iq_valid_in), .lb_iq(lb_iq), .lb_iq_valid_in(lb_iq_valid_in),
    .fifo_emptyn(fifo_emptyn), .drop_clr(drop_clr), .bw20_iq(bw20_iq), .bw20_iq_valid(bw20_iq_valid),
    .fifo_in_en(fifo_in_en), .fifo_out_en(fifo_out_en), .fifo_rstn(fifo_rstn),
    .src_sel_active(src_sel_active), .busy(busy), .drop_count(drop_count),
    .drain_timeout_flag(drain_timeout_flag)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        rf_v;
    logic [63:0] rf_d;
    logic        lb_v;
    logic [63:0] lb_d;
    logic        exp_v;
    logic [63:0] exp_d;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic pulse_apply(input logic [1:0] r);
    src_sel_req   = r;
    src_sel_apply = 1'b1;
    step();
    src_sel_apply = 1'b0;
  endtask

  task automatic wait_run(input string name, input int bound);
    int n = 0;
    while (fifo_in_en !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(name, 64'(fifo_in_en), 64'(1));
  endtask

  // Counts consecutive gate/drain cycles; optionally empties the FIFO after drop_at of them.
  task automatic measure_drain(input int drop_at, output int cnt);
    cnt = 0;
    while (fifo_in_en == 1'b0 && fifo_out_en == 1'b1 && cnt < 400) begin
      cnt++;
      if (drop_at > 0 && cnt == drop_at) fifo_emptyn = 1'b0;
      step();
    end
  endtask

  initial begin
    int exp_drop;
    int cnt;
    int n;
    logic [63:0] exp_d;

    tbl[0] = '{1'b1, 64'h1111_2222_3333_4444, 1'b0, 64'h0, 1'b1, 64'h1111_2222_3333_4444};
    tbl[1] = '{1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'h0, 1'b0, 64'h0};
    tbl[2] = '{1'b0, 64'h0, 1'b1, 64'hAAAA_5555_AAAA_5555, 1'b0, 64'h0};
    tbl[3] = '{1'b1, 64'h8000_7FFF_0001_FFFE, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b1, 64'h8000_7FFF_0001_FFFE};
    tbl[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{1'b1, 64'h0, 1'b0, 64'h0, 1'b1, 64'h0};

    rstn = 1'b0; src_sel_req = 2'd0; src_sel_apply = 1'b0;
    rf_iq = '0; lb_iq = '0; rf_iq_valid_in = 1'b0; lb_iq_valid_in = 1'b0;
    fifo_emptyn = 1'b0; drop_clr = 1'b0;
    repeat (3) step();
    chk("rst_fifo_rstn", 64'(fifo_rstn), 64'(0));
    chk("rst_in_en", 64'(fifo_in_en), 64'(0));
    chk("rst_out_en", 64'(fifo_out_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_valid", 64'(bw20_iq_valid), 64'(0));
    chk("rst_iq", bw20_iq, 64'(0));
    chk("rst_active", 64'(src_sel_active), 64'(0));
    chk("rst_drop", 64'(drop_count), 64'(0));
    chk("rst_flag", 64'(drain_timeout_flag), 64'(0));

    // Reset release: flush for 8 edges, settle for 2, RUN at edge 10.
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("boot%0d_fifo_rstn", k), 64'(fifo_rstn), 64'(k >= 8));
      chk($sformatf("boot%0d_in_en", k), 64'(fifo_in_en), 64'(k >= 10));
      chk($sformatf("boot%0d_busy", k), 64'(busy), 64'(k < 10));
    end
    chk("boot_active", 64'(src_sel_active), 64'(0));

    // Mux vectors with RF active.
    for (int i = 0; i < 6; i++) begin
      rf_iq_valid_in = tbl[i].rf_v; rf_iq = tbl[i].rf_d;
      lb_iq_valid_in = tbl[i].lb_v; lb_iq = tbl[i].lb_d;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(bw20_iq_valid), 64'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("vec%0d_iq", i), bw20_iq, tbl[i].exp_d);
    end
    lb_iq_valid_in = 1'b0;

    // Switch RF -> pattern with an empty FIFO; RF strobe in the apply cycle is still forwarded.
    rf_iq_valid_in = 1'b1; rf_iq = 64'h0123_4567_89AB_CDEF;
    pulse_apply(2'd2);
    exp_drop = 0;
    for (int k = 1; k <= 24; k++) begin
      chk($sformatf("sw%0d_in_en", k), 64'(fifo_in_en), 64'(k >= 13));
      chk($sformatf("sw%0d_out_en", k), 64'(fifo_out_en), 64'((k <= 2) || (k >= 13)));
      chk($sformatf("sw%0d_fifo_rstn", k), 64'(fifo_rstn), 64'(!(k >= 3 && k <= 10)));
      chk($sformatf("sw%0d_active", k), 64'(src_sel_active), (k >= 11) ? 64'(2) : 64'(0));
      chk($sformatf("sw%0d_valid", k), 64'(bw20_iq_valid), 64'((k == 1) || (k == 18) || (k == 23)));
      if (k == 1)  chk("sw_last_rf_iq", bw20_iq, 64'h0123_4567_89AB_CDEF);
      if (k == 18) chk("pat0_iq", bw20_iq, 64'hFFFE_0001_FFFF_0000);
      if (k == 23) chk("pat1_iq", bw20_iq, 64'hFFFD_0002_FFFE_0001);
      if (k == 13) chk("sw_drop_count", 64'(drop_count), 64'(exp_drop));
      rf_iq_valid_in = ((k % 5) == 1) && (k <= 12);
      if (rf_iq_valid_in) exp_drop++;
      step();
    end
    rf_iq_valid_in = 1'b0;

    // Apply matching the active source is ignored.
    pulse_apply(2'd2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("same%0d_busy", k), 64'(busy), 64'(0));
      step();
    end

    // Drain with data for 30 gate/drain cycles.
    fifo_emptyn = 1'b1;
    pulse_apply(2'd0);
    measure_drain(30, cnt);
    chk("drain30_len", 64'(cnt), 64'(30));
    chk("drain30_flush", 64'(fifo_rstn), 64'(0));
    chk("drain30_flag", 64'(drain_timeout_flag), 64'(0));
    wait_run("drain30_run", 40);

    // Drain timeout: 1 gate + 200 drain cycles.
    fifo_emptyn = 1'b1;
    pulse_apply(2'd1);
    measure_drain(0, cnt);
    chk("tmo_len", 64'(cnt), 64'(201));
    chk("tmo_flush", 64'(fifo_rstn), 64'(0));
    chk("tmo_flag", 64'(drain_timeout_flag), 64'(1));
    fifo_emptyn = 1'b0;
    wait_run("tmo_run", 40);
    chk("tmo_flag_sticky", 64'(drain_timeout_flag), 64'(1));
    chk("tmo_active", 64'(src_sel_active), 64'(1));
    drop_clr = 1'b1; step(); drop_clr = 1'b0;
    chk("tmo_flag_clr", 64'(drain_timeout_flag), 64'(0));

    // Pending: two applies during FLUSH, the later one wins and runs automatically.
    pulse_apply(2'd0);
    step(); step();
    pulse_apply(2'd1);
    step();
    pulse_apply(2'd2);
    wait_run("pend_run1", 40);
    chk("pend_active1", 64'(src_sel_active), 64'(0));
    step();
    chk("pend_restart", 64'(fifo_in_en), 64'(0));
    wait_run("pend_run2", 40);
    chk("pend_active2", 64'(src_sel_active), 64'(2));
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("pend_idle%0d", k), 64'(busy), 64'(0));
    end

    // Drops are charged to the pre-switch source only.
    rf_iq_valid_in = 1'b1;
    drop_clr = 1'b1; step(); drop_clr = 1'b0;
    pulse_apply(2'd0);
    wait_run("drop_pat_run", 40);
    chk("drop_pat_none", 64'(drop_count), 64'(0));
    pulse_apply(2'd1);
    wait_run("drop_rf_run", 40);
    chk("drop_rf_12", 64'(drop_count), 64'(12));
    lb_iq_valid_in = 1'b1;
    pulse_apply(2'd0);
    step(); step(); step();
    drop_clr = 1'b1; step(); drop_clr = 1'b0;
    chk("drop_clr_with_strobe", 64'(drop_count), 64'(0));
    step();
    chk("drop_after_clr", 64'(drop_count), 64'(1));
    wait_run("drop_clr_run", 40);

    // Saturation: keep switching with both sources strobing and drains timing out.
    fifo_emptyn = 1'b1;
    n = 0;
    while (drop_count !== 16'hFFFF && n < 80000) begin
      src_sel_apply = 1'b0;
      if (fifo_in_en) begin
        src_sel_req   = (src_sel_active == 2'd0) ? 2'd1 : 2'd0;
        src_sel_apply = 1'b1;
      end
      step();
      n++;
    end
    src_sel_apply = 1'b0;
    chk("sat_reach", 64'(drop_count), 64'hFFFF);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    repeat (20) step();
    chk("sat_hold", 64'(drop_count), 64'hFFFF);
    chk("sat_flag", 64'(drain_timeout_flag), 64'(1));

    // Reset in the middle of a switch with a pending request.
    pulse_apply(2'd2);
    rstn = 1'b0;
    step();
    chk("mid_rst_fifo_rstn", 64'(fifo_rstn), 64'(0));
    chk("mid_rst_out_en", 64'(fifo_out_en), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(1));
    chk("mid_rst_drop", 64'(drop_count), 64'(0));
    chk("mid_rst_flag", 64'(drain_timeout_flag), 64'(0));
    chk("mid_rst_active", 64'(src_sel_active), 64'(0));
    rstn = 1'b1;
    fifo_emptyn = 1'b0; rf_iq_valid_in = 1'b0; lb_iq_valid_in = 1'b0;
    wait_run("mid_rst_run", 20);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mid_rst_idle%0d", k), 64'(busy), 64'(0));
    end
    chk("mid_rst_active_after", 64'(src_sel_active), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/rx_iq_src_ctrl.md
# rx_iq_src_ctrl

Source scheduler in front of the receive I/Q FIFO interface. It arbitrates between three 20 Msps I/Q sources: RF front-end, TX loopback and an internal ramp pattern. It drives the FIFO write/read enables and a local FIFO reset. Source changes are sequenced with gate → drain → flush → settle, so the OFDM receiver never sees samples from two sources interleaved.

## Interface
Parameters:
- IQ_DATA_WIDTH, 16, width of each I/Q component
- FLUSH_CYCLES, 8, cycles fifo_rstn is held low per flush (1..255)
- DRAIN_TIMEOUT, 200, maximum drain cycles before forced flush (1..255)
- PATTERN_PERIOD, 5, clocks between ramp-pattern samples (2..31)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- src_sel_req  in  2  requested source: 0 RF, 1 loopback, 2 pattern, 3 reserved (treated as 0)
- src_sel_apply  in  1  one-cycle pulse; latches src_sel_req
- rf_iq  in  4*IQ_DATA_WIDTH  RF sample {q1,i1,q0,i0}
- rf_iq_valid_in  in  1  RF sample strobe
- lb_iq  in  4*IQ_DATA_WIDTH  loopback sample, same packing
- lb_iq_valid_in  in  1  loopback sample strobe
- fifo_emptyn  in  1  FIFO not-empty status from the I/Q interface
- drop_clr  in  1  clears drop_count and drain_timeout_flag
- bw20_iq  out  4*IQ_DATA_WIDTH  selected sample to FIFO write side
- bw20_iq_valid  out  1  selected sample strobe
- fifo_in_en  out  1  FIFO write enable gate
- fifo_out_en  out  1  FIFO read enable gate
- fifo_rstn  out  1  local FIFO reset, active-low
- src_sel_active  out  2  source currently routed
- busy  out  1  high whenever the state is not RUN
- drop_count  out  16  saturating count of discarded samples
- drain_timeout_flag  out  1  sticky; a drain hit DRAIN_TIMEOUT

## Operation
- Mux: in RUN, active source data and strobe are registered to bw20_iq/bw20_iq_valid. Sources that are not selected are ignored.
- Pattern source: a 5-bit divider fires every PATTERN_PERIOD clocks. An IQ_DATA_WIDTH ramp r increments on each fire and wraps at 2^IQ_DATA_WIDTH. The sample is i0=r, q0=~r, i1=r+1, q1=~(r+1). The ramp resets to 0 on every entry into RUN.
- States:
  - RUN: in_en=1, out_en=1, fifo_rstn=1.
  - GATE: in_en=0, out_en=1; lasts 1 cycle.
  - DRAIN: in_en=0, out_en=1. Exits when fifo_emptyn=0 or when the drain counter reaches DRAIN_TIMEOUT. On timeout, set drain_timeout_flag.
  - FLUSH: in_en=0, out_en=0, fifo_rstn=0 for FLUSH_CYCLES cycles.
  - SETTLE: fifo_rstn=1, enables still 0, for 2 cycles. src_sel_active takes the pending value on entry.
  - SETTLE → RUN.
- Request handling: src_sel_apply in RUN with req≠active starts the GATE sequence. If req==active, the apply is ignored.
- Apply outside RUN: stored in a one-deep pending register, where a later apply overwrites an earlier one. After returning to RUN, a pending entry that differs from active restarts the sequence on the next cycle. A pending entry equal to active is discarded.
- drop_count: increments by 1 for every strobe of the active (pre-switch) source while in_en=0. Saturates at 0xFFFF. drop_clr takes priority over an increment in the same cycle.

## Timing
- Reset (rstn=0), all outputs: bw20_iq=0, bw20_iq_valid=0, fifo_in_en=0, fifo_out_en=0, fifo_rstn=0, src_sel_active=0, busy=1, drop_count=0, drain_timeout_flag=0; pending cleared.
- First cycle after reset: FLUSH (full FLUSH_CYCLES), then SETTLE, then RUN. Outputs are stable in RUN at cycle FLUSH_CYCLES+2 after rstn rises.
- Mux latency: 1 cycle from source strobe to bw20_iq_valid.
- fifo_in_en drops on the cycle after the apply. The last sample of the old source is forwarded only if its strobe arrived in the apply cycle.
- Total switch time:
  - With an empty FIFO: 1 (GATE) + 1 (DRAIN exit check) + FLUSH_CYCLES + 2.
  - With a non-empty FIFO: drain length is bounded by DRAIN_TIMEOUT.
- bw20_iq_valid is forced 0 outside RUN.
- All outputs are registered. rstn asserted mid-switch aborts the sequence immediately to reset values.

## Test plan
- Reset release, defaults: fifo_rstn low for 8 cycles after rstn rises, RUN at cycle 10, src_sel_active=0, RF strobe forwarded 1 cycle later with identical data.
- Switch to pattern, FIFO empty: apply req=2 → in_en=0 next cycle, FLUSH 8 cycles, RUN after 12 cycles. Pattern samples every 5 clocks: i0=0x0000, q0=0xFFFF, then i0=0x0001, q0=0xFFFE.
- Drain with data: fifo_emptyn held 1 for 30 cycles during DRAIN → out_en stays 1 for 30 cycles, then FLUSH; no timeout flag.
- Drain timeout: fifo_emptyn stuck 1 → FLUSH entered after 200 drain cycles, drain_timeout_flag=1 until drop_clr.
- Pending request: apply req=1 then req=2 during FLUSH → after RUN, a second sequence runs automatically and ends with src_sel_active=2. An apply with req equal to active in RUN → no state change.
- Drop count: RF strobing every 5 clocks during a 12-cycle switch → drop_count increments by 2 or 3. Preset near 0xFFFF → saturates at 0xFFFF. drop_clr with a simultaneous strobe → 0.
